// File: rtl/decoder_nxm_skid_pkg.sv
// Shared types and the decode function for the pipelined N-to-2^N decoder.
package decoder_nxm_skid_pkg;

  typedef enum logic {
    DEC_ONEHOT = 1'b0,
    DEC_THERMO = 1'b1
  } dec_mode_e;

  // The decode function works on the widest supported word; callers keep the low OUT_W bits.
  localparam int DEC_MAX_IN_W  = 8;
  localparam int DEC_MAX_OUT_W = 1 << DEC_MAX_IN_W;

  function automatic int dec_out_w(input int in_w);
    return 1 << in_w;
  endfunction

  function automatic logic [DEC_MAX_OUT_W-1:0] decode(
    input logic [DEC_MAX_IN_W-1:0] index,
    input logic                    enable,
    input dec_mode_e               mode,
    input int                      out_w
  );
    logic [DEC_MAX_OUT_W-1:0] word;
    word = '0;
    for (int i = 0; i < DEC_MAX_OUT_W; i++) begin
      if (enable && (i < out_w)) begin
        if (mode == DEC_ONEHOT) word[i] = (i == int'(index));
        else                    word[i] = (i <= int'(index));
      end
    end
    return word;
  endfunction

endpackage

// File: rtl/decoder_nxm_skid_if.sv
// Upstream request and downstream result handshake bundle for decoder_nxm_skid.
interface decoder_nxm_skid_if
  import decoder_nxm_skid_pkg::*;
#(
  parameter int IN_W = 2
);
  localparam int OUT_W = dec_out_w(IN_W);

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_index;
  logic             in_enable;
  logic             in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [IN_W-1:0]  out_index;

  modport slave (
    input  in_valid, in_index, in_enable, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_index
  );

  modport master (
    output in_valid, in_index, in_enable, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_index
  );
endinterface

// File: rtl/decoder_nxm_skid_buffer.sv
// Two-entry skid buffer: main entry drives the outputs, skid entry absorbs one stalled beat.
module decoder_nxm_skid_buffer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o
);

  logic              main_vld_q, main_vld_d;
  logic              skid_vld_q, skid_vld_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              accept;
  logic              main_free;

  // in_ready comes straight from a flop, so out_ready never reaches it combinationally.
  assign accept    = in_valid_i && !skid_vld_q;
  assign main_free = !main_vld_q || out_ready_i;

  always_comb begin
    main_vld_d  = main_vld_q;
    main_data_d = main_data_q;
    skid_vld_d  = skid_vld_q;
    skid_data_d = skid_data_q;
    if (main_free) begin
      if (skid_vld_q) begin
        main_vld_d  = 1'b1;
        main_data_d = skid_data_q;
        skid_vld_d  = 1'b0;
      end else if (accept) begin
        main_vld_d  = 1'b1;
        main_data_d = in_data_i;
      end else begin
        main_vld_d  = 1'b0;
      end
    end else if (accept) begin
      skid_vld_d  = 1'b1;
      skid_data_d = in_data_i;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_vld_q  <= 1'b0;
      skid_vld_q  <= 1'b0;
      main_data_q <= '0;
      skid_data_q <= '0;
    end else begin
      main_vld_q  <= main_vld_d;
      skid_vld_q  <= skid_vld_d;
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
    end
  end

  assign in_ready_o  = !skid_vld_q;
  assign out_valid_o = main_vld_q;
  assign out_data_o  = main_data_q;

endmodule

// File: rtl/decoder_nxm_skid.sv
// N-to-2^N one-hot/thermometer decoder with a registered, back-pressured skid output.
module decoder_nxm_skid
  import decoder_nxm_skid_pkg::*;
#(
  parameter int IN_W = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  decoder_nxm_skid_if.slave  bus
);

  localparam int OUT_W  = dec_out_w(IN_W);
  localparam int DATA_W = OUT_W + IN_W;

  logic [DEC_MAX_IN_W-1:0]  idx_wide;
  logic [DEC_MAX_OUT_W-1:0] dec_full;
  logic [OUT_W-1:0]         dec_word;
  logic [DATA_W-1:0]        out_word;

  always_comb begin
    idx_wide             = '0;
    idx_wide[IN_W-1:0]   = bus.in_index;
  end

  // Decoding happens before the buffer so only the accepted word is ever stored.
  assign dec_full = decode(idx_wide, bus.in_enable, dec_mode_e'(bus.in_mode), OUT_W);
  assign dec_word = dec_full[OUT_W-1:0];

  if (OUT_W < DEC_MAX_OUT_W) begin : g_hi_bits
    logic unused_hi;
    assign unused_hi = ^dec_full[DEC_MAX_OUT_W-1:OUT_W];
  end

  decoder_nxm_skid_buffer #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid_i  (bus.in_valid),
    .in_ready_o  (bus.in_ready),
    .in_data_i   ({dec_word, bus.in_index}),
    .out_valid_o (bus.out_valid),
    .out_ready_i (bus.out_ready),
    .out_data_o  (out_word)
  );

  assign bus.out_data  = out_word[DATA_W-1:IN_W];
  assign bus.out_index = out_word[IN_W-1:0];

endmodule

// File: tb/tb_decoder_nxm_skid.sv
// Bench for decoder_nxm_skid: vector table, stall/reset sequences and a scoreboard.
module tb_decoder_nxm_skid;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;

  decoder_nxm_skid_if #(.IN_W(2)) bus2 ();
  decoder_nxm_skid_if #(.IN_W(4)) bus4 ();

  decoder_nxm_skid #(.IN_W(2)) u_dut2 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus2.slave)
  );

  decoder_nxm_skid #(.IN_W(4)) u_dut4 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    bit         en;
    bit         md;
    logic [3:0] exp;
  } vec_t;

  vec_t       vecs[10];
  logic [5:0] exp_q[$];

  function automatic logic [31:0] ref_dec(input int idx, input bit en, input bit md);
    if (!en)       return 32'd0;
    else if (!md)  return 32'd1 << idx;
    else           return (32'd1 << (idx + 1)) - 32'd1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive2(input bit v, input int idx, input bit en, input bit md);
    bus2.in_valid  = v;
    bus2.in_index  = 2'(idx);
    bus2.in_enable = en;
    bus2.in_mode   = md;
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  initial begin
    logic       hold_vld;
    logic [5:0] hold_word;
    logic [5:0] got;
    logic [5:0] want;
    logic [3:0] d;
    hold_vld  = 1'b0;
    hold_word = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        hold_vld = 1'b0;
      end else begin
        got = {bus2.out_data, bus2.out_index};
        if (hold_vld) begin
          check("stall_valid_held", 32'(bus2.out_valid), 32'd1);
          check("stall_word_held", 32'(got), 32'(hold_word));
        end
        if (bus2.out_valid && bus2.out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected_output actual=%0h required=none", got);
          end else begin
            want = exp_q.pop_front();
            check("sb_word", 32'(got), 32'(want));
          end
        end
        if (bus2.in_valid && bus2.in_ready) begin
          d = 4'(ref_dec(int'(bus2.in_index), bus2.in_enable, bus2.in_mode));
          exp_q.push_back({d, bus2.in_index});
        end
        hold_vld  = bus2.out_valid && !bus2.out_ready;
        hold_word = got;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int  sent;
    bit  rdy_seen;
    int  k;
    checks   = 0;
    failures = 0;

    vecs[0] = '{0, 1'b1, 1'b0, 4'b0001};
    vecs[1] = '{1, 1'b1, 1'b0, 4'b0010};
    vecs[2] = '{2, 1'b1, 1'b0, 4'b0100};
    vecs[3] = '{3, 1'b1, 1'b0, 4'b1000};
    vecs[4] = '{0, 1'b1, 1'b1, 4'b0001};
    vecs[5] = '{1, 1'b1, 1'b1, 4'b0011};
    vecs[6] = '{2, 1'b1, 1'b1, 4'b0111};
    vecs[7] = '{3, 1'b1, 1'b1, 4'b1111};
    vecs[8] = '{3, 1'b0, 1'b0, 4'b0000};
    vecs[9] = '{3, 1'b0, 1'b1, 4'b0000};

    reset_n        = 1'b1;
    drive2(0, 0, 0, 0);
    bus2.out_ready = 1'b1;
    bus4.in_valid  = 1'b0;
    bus4.in_index  = 4'd0;
    bus4.in_enable = 1'b0;
    bus4.in_mode   = 1'b0;
    bus4.out_ready = 1'b1;

    // Reset state
    #2 reset_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(bus2.out_valid), 32'd0);
    check("rst_out_data", 32'(bus2.out_data), 32'd0);
    check("rst_out_index", 32'(bus2.out_index), 32'd0);
    check("rst_in_ready", 32'(bus2.in_ready), 32'd1);
    check("rst_out_valid_w4", 32'(bus4.out_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Back-to-back vector table, one result per cycle
    @(posedge clk); #1;
    check("pre_first_valid", 32'(bus2.out_valid), 32'd0);
    drive2(1, vecs[0].idx, vecs[0].en, vecs[0].md);
    @(negedge clk);
    check("no_result_before_accept", 32'(bus2.out_valid), 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check($sformatf("vec%0d_valid", i), 32'(bus2.out_valid), 32'd1);
      check($sformatf("vec%0d_data", i), 32'(bus2.out_data), 32'(vecs[i].exp));
      check($sformatf("vec%0d_index", i), 32'(bus2.out_index), 32'(vecs[i].idx));
      if (i < 9) drive2(1, vecs[i+1].idx, vecs[i+1].en, vecs[i+1].md);
      else       bus2.in_valid = 1'b0;
    end
    @(posedge clk); #1;
    check("table_drained", 32'(bus2.out_valid), 32'd0);

    // Stall: fill main and skid, third request blocked, then release
    bus2.out_ready = 1'b0;
    drive2(1, 1, 1, 0);
    @(posedge clk); #1;
    check("stall_first_data", 32'(bus2.out_data), 32'h2);
    check("stall_ready_one_entry", 32'(bus2.in_ready), 32'd1);
    drive2(1, 2, 1, 0);
    @(posedge clk); #1;
    check("stall_ready_drop", 32'(bus2.in_ready), 32'd0);
    check("stall_main_kept", 32'(bus2.out_data), 32'h2);
    drive2(1, 3, 1, 0);
    @(posedge clk); #1;
    check("third_blocked_ready", 32'(bus2.in_ready), 32'd0);
    check("third_blocked_data", 32'(bus2.out_data), 32'h2);
    bus2.out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_skid_data", 32'(bus2.out_data), 32'h4);
    check("release_ready_back", 32'(bus2.in_ready), 32'd1);
    @(posedge clk); #1;
    check("release_third_data", 32'(bus2.out_data), 32'h8);
    bus2.in_valid = 1'b0;
    @(posedge clk); #1;
    check("release_empty", 32'(bus2.out_valid), 32'd0);

    // Random traffic, 200 transactions; upstream holds a request until taken
    sent = 0;
    while (sent < 200) begin
      if (!bus2.in_valid && ($urandom_range(0, 3) != 0))
        drive2(1, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      bus2.out_ready = ($urandom_range(0, 3) != 0);
      rdy_seen = bus2.in_ready;
      @(posedge clk); #1;
      if (bus2.in_valid && rdy_seen) begin
        sent++;
        bus2.in_valid = 1'b0;
      end
    end
    bus2.out_ready = 1'b1;
    k = 0;
    while (k < 50 && (exp_q.size() != 0 || bus2.out_valid)) begin
      @(posedge clk); #1;
      k++;
    end
    check("random_sb_drained", 32'(exp_q.size()), 32'd0);
    check("random_out_idle", 32'(bus2.out_valid), 32'd0);

    // Reset while both entries are full
    bus2.out_ready = 1'b0;
    drive2(1, 0, 1, 1);
    @(posedge clk); #1;
    drive2(1, 1, 1, 1);
    @(posedge clk); #1;
    bus2.in_valid = 1'b0;
    check("full_ready_low", 32'(bus2.in_ready), 32'd0);
    check("full_valid_high", 32'(bus2.out_valid), 32'd1);
    @(negedge clk); #2;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check("async_rst_valid", 32'(bus2.out_valid), 32'd0);
    check("async_rst_data", 32'(bus2.out_data), 32'd0);
    check("async_rst_index", 32'(bus2.out_index), 32'd0);
    check("async_rst_ready", 32'(bus2.in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    bus2.out_ready = 1'b1;
    drive2(1, 2, 1, 1);
    @(posedge clk); #1;
    check("post_rst_valid", 32'(bus2.out_valid), 32'd1);
    check("post_rst_data", 32'(bus2.out_data), 32'h7);
    check("post_rst_index", 32'(bus2.out_index), 32'd2);
    bus2.in_valid = 1'b0;
    @(posedge clk); #1;
    check("post_rst_single", 32'(bus2.out_valid), 32'd0);

    // Wide build, IN_W=4
    bus4.in_valid  = 1'b1;
    bus4.in_index  = 4'd15;
    bus4.in_enable = 1'b1;
    bus4.in_mode   = 1'b1;
    @(posedge clk); #1;
    check("w4_thermo15_data", 32'(bus4.out_data), 32'hFFFF);
    check("w4_thermo15_index", 32'(bus4.out_index), 32'd15);
    bus4.in_index = 4'd9;
    bus4.in_mode  = 1'b0;
    @(posedge clk); #1;
    check("w4_onehot9_data", 32'(bus4.out_data), 32'h0200);
    check("w4_onehot9_index", 32'(bus4.out_index), 32'd9);
    bus4.in_valid = 1'b0;
    @(posedge clk); #1;
    check("w4_idle", 32'(bus4.out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
